tuart_rx: RTL and testbench

UART receiver for the logIP host link: the receive-side counterpart of the `tuart_tx` transmitter. It recovers 8N1-style frames from the asynchronous `rx_i` line and presents each received word to the command decoder. Output uses a valid/ack handshake. Framing errors and overruns are flagged. It sits between the top-level RX pin and the SUMP command parser.

---
 rtl/tuart_rx.sv | 170 +++++++++++++++++
 tb/tb_tuart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tuart_rx.sv
// tuart_rx: UART receiver, 8N1-style frames (no parity, one stop bit, LSB first).
// Recovers words from the asynchronous rx_i line and hands them to the consumer
// over a valid/ack handshake. Stop-bit errors and overwritten words are flagged.
//
// Ports:
//   clk_i     - system clock, rising edge
//   rst_i     - asynchronous active-high reset
//   rx_i      - serial line, idle high, asynchronous to clk_i
//   data_o    - last received word
//   valid_o   - data_o holds an unacknowledged word
//   ack_i     - consumer accepts data_o (ignored while valid_o = 0)
//   ferr_o    - one-cycle pulse when a stop bit is sampled low
//   overrun_o - sticky, set when an unacknowledged word is overwritten
module tuart_rx #(
    parameter int unsigned CYCLES_PER_BIT = 104,
    parameter int unsigned WORD_BITS      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ack_i,
    output logic                 ferr_o,
    output logic                 overrun_o
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int unsigned IDX_W = $clog2(WORD_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [WORD_BITS-1:0] sh, sh_n;
    logic [WORD_BITS-1:0] data_n;
    logic                 valid_n;
    logic                 ferr_n;
    logic                 overrun_n;
    logic                 rx_meta;
    logic                 rx_s;
    logic [WORD_BITS:0]   shift_in;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // New sample enters at the MSB so LSB-first bits end up in order
    assign shift_in = {rx_s, sh};

    // Next-state, datapath and output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        sh_n      = sh;
        data_n    = data_o;
        valid_n   = valid_o;
        ferr_n    = 1'b0;
        overrun_n = overrun_o;

        // Ack clears valid; a commit below in the same cycle overrides this
        if (valid_o && ack_i) begin
            valid_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_LOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt_n   = BIT_LOAD;
                        idx_n   = '0;
                        state_n = S_DATA;
                    end else begin
                        // Start bit gone by mid-bit: glitch
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    sh_n  = shift_in[WORD_BITS:1];
                    idx_n = idx + IDX_W'(1);
                    cnt_n = BIT_LOAD;
                    if (idx == LAST_IDX) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        data_n  = sh;
                        valid_n = 1'b1;
                        if (valid_o && !ack_i) begin
                            overrun_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not a start bit
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            ferr_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            data_o    <= data_n;
            valid_o   <= valid_n;
            ferr_o    <= ferr_n;
            overrun_o <= overrun_n;
        end
    end

endmodule

// File: tb/tb_tuart_rx.sv
// tb_tuart_rx: directed bench for tuart_rx at 16 cycles/bit, 8-bit words.
// Expected words are queued when a frame is sent and popped when the
// receiver commits it; timing checks are made on exact cycle offsets.
module tb_tuart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned WB  = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rx_i;
    logic          ack_i;
    logic [WB-1:0] data_o;
    logic          valid_o;
    logic          ferr_o;
    logic          overrun_o;

    int tests = 0;
    int fails = 0;
    logic [WB-1:0] sb[$];

    tuart_rx #(
        .CYCLES_PER_BIT(CPB),
        .WORD_BITS     (WB)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ack_i    (ack_i),
        .ferr_o   (ferr_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected word and compare against data_o
    task automatic check_word(input string tag);
        logic [WB-1:0] exp;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty, observed 0x%0h expected a queued word", tag, data_o);
        end else begin
            exp = sb.pop_front();
            check(tag, 32'(data_o), 32'(exp));
        end
    endtask

    // Start bit plus data bits (9 bit periods); returns 1 unit past edge e0+144
    task automatic send_body(input logic [WB-1:0] d, input bit expect_commit);
        if (expect_commit) sb.push_back(d);
        rx_i = 1'b0;
        tick(CPB);
        for (int k = 0; k < WB; k++) begin
            rx_i = d[k];
            tick(CPB);
        end
    endtask

    // Full good frame; the commit edge is e0+155 (t0 = e0+3, +H+9C)
    task automatic send_frame(input logic [WB-1:0] d, input string tag);
        send_body(d, 1'b1);
        rx_i = 1'b1;
        tick(11);
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_noferr"}, 32'(ferr_o), 32'd0);
        tick(5);
    endtask

    task automatic ack_pulse();
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        rx_i  = 1'b1;
        ack_i = 1'b0;
        tick(3);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ferr", 32'(ferr_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        rst_i = 1'b0;
        tick(20);

        // Basic receive with exact commit timing
        send_body(8'hA5, 1'b1);
        rx_i = 1'b1;
        tick(10);
        check("basic_valid_early", 32'(valid_o), 32'd0);
        tick(1);
        check("basic_valid", 32'(valid_o), 32'd1);
        check_word("basic_data");
        check("basic_ferr", 32'(ferr_o), 32'd0);
        check("basic_overrun", 32'(overrun_o), 32'd0);
        tick(5);
        check("basic_valid_held", 32'(valid_o), 32'd1);
        ack_pulse();
        check("basic_ack", 32'(valid_o), 32'd0);

        // Glitch rejection
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(20);
        check("glitch_valid", 32'(valid_o), 32'd0);
        check("glitch_ferr", 32'(ferr_o), 32'd0);
        send_frame(8'h3C, "glitch_next");
        check_word("glitch_next_data");
        ack_pulse();
        check("glitch_ack", 32'(valid_o), 32'd0);

        // Framing error followed by a break
        send_body(8'h3C, 1'b0);
        rx_i = 1'b0;
        tick(10);
        check("ferr_early", 32'(ferr_o), 32'd0);
        tick(1);
        check("ferr_pulse", 32'(ferr_o), 32'd1);
        check("ferr_valid", 32'(valid_o), 32'd0);
        tick(1);
        check("ferr_one_cycle", 32'(ferr_o), 32'd0);
        tick(40);
        check("break_valid", 32'(valid_o), 32'd0);
        check("break_ferr", 32'(ferr_o), 32'd0);
        rx_i = 1'b1;
        tick(20);
        check("break_valid_after", 32'(valid_o), 32'd0);
        send_frame(8'h5A, "after_break");
        check_word("after_break_data");
        ack_pulse();
        check("after_break_ack", 32'(valid_o), 32'd0);

        // Ack on the same edge as the next commit
        send_frame(8'h11, "ackc_first");
        check_word("ackc_first_data");
        send_body(8'h22, 1'b1);
        rx_i = 1'b1;
        tick(10);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        check("ackc_valid", 32'(valid_o), 32'd1);
        check_word("ackc_data");
        check("ackc_overrun", 32'(overrun_o), 32'd0);
        tick(1);
        check("ackc_valid_next", 32'(valid_o), 32'd1);
        tick(4);
        ack_pulse();
        check("ackc_ack", 32'(valid_o), 32'd0);
        check("ackc_overrun_after", 32'(overrun_o), 32'd0);

        // Overrun on back-to-back frames without ack
        send_frame(8'h11, "ovr_first");
        check_word("ovr_first_data");
        check("ovr_first_flag", 32'(overrun_o), 32'd0);
        send_frame(8'h22, "ovr_second");
        check_word("ovr_second_data");
        check("ovr_flag", 32'(overrun_o), 32'd1);
        ack_pulse();
        check("ovr_ack_valid", 32'(valid_o), 32'd0);
        check("ovr_sticky", 32'(overrun_o), 32'd1);
        tick(5);
        check("ovr_sticky_later", 32'(overrun_o), 32'd1);

        // Reset during data bit 4 of 0x77 (bit 4 is 1, so the line is high)
        rx_i = 1'b0;
        tick(CPB);
        for (int k = 0; k < 4; k++) begin
            rx_i = (k == 3) ? 1'b0 : 1'b1;
            tick(CPB);
        end
        rx_i = 1'b1;
        tick(5);
        rst_i = 1'b1;
        tick(1);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_ferr", 32'(ferr_o), 32'd0);
        check("midrst_overrun", 32'(overrun_o), 32'd0);
        tick(2);
        rst_i = 1'b0;
        tick(20);
        check("midrst_idle_valid", 32'(valid_o), 32'd0);
        send_frame(8'hFF, "midrst_next");
        check_word("midrst_next_data");
        check("midrst_next_overrun", 32'(overrun_o), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
